// File: rtl/stream_mux_rr.sv
// ---------------------------------------------------------------------------
// stream_mux_rr : N:1 valid/ready stream mux, fixed-select or round-robin, registered output
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module stream_mux_rr #(
  parameter int WIDTH = 4,
  parameter int N_CH  = 4,
  parameter int SEL_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_ch,
  output logic                  out_valid,
  input  logic                  out_ready
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [SEL_W-1:0] r_out_ch;
  logic [SEL_W-1:0] r_ptr;

  logic             w_slot_free;
  logic             w_found;
  logic             w_grant;
  logic [SEL_W-1:0] w_cand;
  logic [SEL_W-1:0] w_idx;
  logic [SEL_W-1:0] w_next_ptr;
  logic [WIDTH-1:0] w_word;

  assign w_slot_free = !r_out_valid || out_ready;
  assign w_grant     = w_found && w_slot_free && !rst;

  // Round-robin scans from the highest offset down so the channel nearest ptr wins.
  always_comb begin
    w_found = 1'b0;
    w_cand  = '0;
    w_idx   = '0;
    if (!mode) begin
      for (int k = 0; k < N_CH; k++) begin
        if (sel == SEL_W'(k) && in_valid[k]) begin
          w_found = 1'b1;
          w_cand  = SEL_W'(k);
        end
      end
    end else begin
      for (int i = N_CH - 1; i >= 0; i--) begin
        w_idx = SEL_W'((int'(r_ptr) + i) % N_CH);
        if (in_valid[w_idx]) begin
          w_found = 1'b1;
          w_cand  = w_idx;
        end
      end
    end
  end

  // Only the granted channel reaches the output mux, so unselected X never propagates.
  always_comb begin
    w_word   = '0;
    in_ready = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (w_cand == SEL_W'(k)) begin
        w_word      = in_data[k*WIDTH +: WIDTH];
        in_ready[k] = w_grant;
      end
    end
  end

  assign w_next_ptr = (w_cand == SEL_W'(N_CH - 1)) ? '0 : w_cand + SEL_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_ptr       <= '0;
    end else if (w_grant) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_word;
      r_out_ch    <= w_cand;
      if (mode) begin
        r_ptr <= w_next_ptr;
      end
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;

endmodule

`default_nettype wire

// File: tb/tb_stream_mux_rr.sv
// ---------------------------------------------------------------------------
// tb_stream_mux_rr : directed + randomized check of stream_mux_rr against a behavioural model
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_stream_mux_rr;

  localparam int WIDTH = 4;
  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N_CH*WIDTH-1:0] in_data;
  logic [N_CH-1:0]       in_valid;
  logic [N_CH-1:0]       in_ready;
  logic                  mode;
  logic [SEL_W-1:0]      sel;
  logic [WIDTH-1:0]      out_data;
  logic [SEL_W-1:0]      out_ch;
  logic                  out_valid;
  logic                  out_ready;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  int m_valid = 0;
  int m_data  = 0;
  int m_ch    = 0;
  int m_ptr   = 0;
  int sb_data[$];
  int sb_ch[$];

  stream_mux_rr #(.WIDTH(WIDTH), .N_CH(N_CH), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .sel(sel), .out_data(out_data), .out_ch(out_ch),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Channel that wins this cycle under the arbitration rules, or -1.
  function automatic int grant_of(input logic r, input logic md, input int s,
                                  input logic [N_CH-1:0] v, input int p,
                                  input int mv, input logic ordy);
    if (r) return -1;
    if (mv != 0 && !ordy) return -1;
    if (!md) return (s < N_CH && v[s] == 1'b1) ? s : -1;
    for (int o = 0; o < N_CH; o++) begin
      int c;
      c = (p + o) % N_CH;
      if (v[c] == 1'b1) return c;
    end
    return -1;
  endfunction

  function automatic int word_of(input int g);
    return int'(in_data[g*WIDTH +: WIDTH]);
  endfunction

  always @(posedge clk) begin
    int g;
    if (rst) begin
      m_valid = 0; m_data = 0; m_ch = 0; m_ptr = 0;
      sb_data.delete();
      sb_ch.delete();
    end else begin
      g = grant_of(rst, mode, int'(sel), in_valid, m_ptr, m_valid, out_ready);
      if (g >= 0) begin
        m_valid = 1; m_data = word_of(g); m_ch = g;
        if (mode) m_ptr = (g + 1) % N_CH;
      end else if (m_valid != 0 && out_ready) begin
        m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    int g;
    logic [N_CH-1:0] exp_ready;
    g = grant_of(rst, mode, int'(sel), in_valid, m_ptr, m_valid, out_ready);
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("out_ch", 32'(out_ch), 32'(m_ch));
    if (!rst && out_valid && out_ready) begin
      if (sb_data.size() == 0) begin
        chk("sb_underflow", 32'(sb_data.size()), 32'd1);
      end else begin
        chk("sb_data", 32'(out_data), 32'(sb_data.pop_front()));
        chk("sb_ch", 32'(out_ch), 32'(sb_ch.pop_front()));
      end
    end
    if (g >= 0) begin
      sb_data.push_back(word_of(g));
      sb_ch.push_back(g);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 4'b1111; in_data = '0; mode = 1'b0; sel = '0; out_ready = 1'b1;

    // Reset holds everything idle
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'h0);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      step();
    end
    rst = 1'b0; sel = 2'd2; in_data = 16'h0A00;
    @(negedge clk);
    chk("fix_in_ready", 32'(in_ready), 32'b0100);
    step();
    in_valid = 4'b0000;
    @(negedge clk);
    chk("fix_data", 32'(out_data), 32'hA);
    chk("fix_ch", 32'(out_ch), 32'd2);
    chk("fix_valid", 32'(out_valid), 32'd1);

    // Backpressure hold
    step();
    sel = 2'd1; in_data = 16'h0050; in_valid = 4'b0010;
    step();
    out_ready = 1'b0; in_data = 16'h0060;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'h0);
      chk("bp_data", 32'(out_data), 32'h5);
      chk("bp_valid", 32'(out_valid), 32'd1);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(in_ready), 32'b0010);
    step();
    in_valid = 4'b0000;
    @(negedge clk);
    chk("bp_next_data", 32'(out_data), 32'h6);

    // Round-robin fairness with every channel requesting
    step();
    mode = 1'b1; in_valid = 4'b1111; in_data = 16'h4321;
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 7) in_valid = 4'b0100;
      @(negedge clk);
      chk("rr_ch", 32'(out_ch), 32'(i % 4));
      chk("rr_data", 32'(out_data), 32'(i % 4 + 1));
      chk("rr_valid", 32'(out_valid), 32'd1);
    end

    // Skip and wrap: ch2 moves ptr to 3, then ch1 then ch3
    chk("wrap_ready0", 32'(in_ready), 32'b0100);
    step();
    in_valid = 4'b0010;
    @(negedge clk);
    chk("wrap_ready1", 32'(in_ready), 32'b0010);
    step();
    in_valid = 4'b1001;
    @(negedge clk);
    chk("wrap_ch1", 32'(out_ch), 32'd1);
    chk("wrap_ready2", 32'(in_ready), 32'b1000);
    step();
    in_valid = 4'b0000; mode = 1'b0; sel = 2'd0;
    @(negedge clk);
    chk("wrap_ch3", 32'(out_ch), 32'd3);
    chk("wrap_data", 32'(out_data), 32'h4);

    // Mode switch with no requests, then ch0
    step();
    step();
    @(negedge clk);
    chk("empty_valid", 32'(out_valid), 32'd0);
    chk("empty_hold_ch", 32'(out_ch), 32'd3);
    step();
    in_valid = 4'b0001; in_data = 16'h432F;
    @(negedge clk);
    chk("sw_ready", 32'(in_ready), 32'b0001);
    step();
    in_valid = 4'b0000; out_ready = 1'b0;
    @(negedge clk);
    chk("sw_data", 32'(out_data), 32'hF);
    chk("sw_ch", 32'(out_ch), 32'd0);

    // Reset during a stall discards the held word
    step();
    rst = 1'b1; in_valid = 4'b1111;
    @(negedge clk);
    chk("rstm_ready", 32'(in_ready), 32'h0);
    step();
    rst = 1'b0; in_valid = 4'b0000;
    @(negedge clk);
    chk("rstm_valid", 32'(out_valid), 32'd0);
    chk("rstm_data", 32'(out_data), 32'd0);
    chk("rstm_ch", 32'(out_ch), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step();
      rst       = ($urandom_range(0, 199) == 0);
      in_valid  = N_CH'($urandom);
      in_data   = (N_CH*WIDTH)'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      sel       = SEL_W'($urandom);
      if ($urandom_range(0, 19) == 0) mode = ~mode;
    end
    step();
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
